conv: RTL and testbench
=======================

# conv

Streaming 3×3 signed convolution engine for the image-filtering datapath. It takes one 3-pixel column per valid cycle from three line memories, or from the CPU in kernel mode, and holds a 3×3 kernel and a 3×3 sliding pixel window. Each valid column produces one fixed-point, truncated result. The result is written back to line memory 0 under the address FSM's write strobe.

## Interface
Parameters:
- BIT_LEN, 8: width of each signed input sample (pixel or kernel coefficient).
- CONV_LEN, 20: full-precision accumulator width (2·BIT_LEN + 4).
- CONV_LPOS, 13: output width; output is the top CONV_LPOS bits of the accumulator.
- M_LEN, 3: kernel/window dimension (fixed at 3).

Ports:
- CLK100MHZ, in, 1: clock; all state updates on the rising edge.
- i_reset, in, 1: asynchronous, active-high reset.
- i_selecK_I, in, 1: 0 = kernel-load mode, 1 = image mode.
- i_valid, in, 1: column strobe; one column is consumed per high cycle.
- i_dato0 / i_dato1 / i_dato2, in, BIT_LEN each: signed column samples for rows 0 / 1 / 2.
- o_data, out, CONV_LPOS: signed convolution result.

## Operation
- State:
  - Kernel K[col][row], 3×3, signed BIT_LEN.
  - Window W[col][row], 3×3, signed BIT_LEN.
  - A 2-stage result pipeline with a valid tag per stage.
- Kernel mode (i_selecK_I = 0), on i_valid:
  - K[2] ← K[1], K[1] ← K[0], K[0] ← {i_dato0, i_dato1, i_dato2}.
  - W is unchanged and no result is launched.
- Image mode (i_selecK_I = 1), on i_valid:
  - The same column shift is applied to W instead of K.
  - A result is launched from the updated W.
- Input column order: three loads place the first column in index 2 and the last in index 0. Kernel and window use the same ordering, so the operation is an element-wise correlation.
- i_valid low: K, W and o_data hold.
- Arithmetic:
  - Nine signed BIT_LEN × BIT_LEN products, each 2·BIT_LEN bits.
  - Sum is sign-extended to CONV_LEN, with no overflow possible for 8-bit operands.
  - o_data = acc[CONV_LEN-1 : CONV_LEN-CONV_LPOS], i.e. an arithmetic shift right by 7 with truncation toward −∞.
  - Coefficients are Q1.7.
- Before three image columns have been shifted in, the window contains reset zeros or stale columns. Results are computed anyway; the address FSM discards them.
- Mode change mid-stream: results already in the pipeline complete normally. Neither K nor W is cleared.

## Timing
- Reset (asynchronous, any time): K = 0, W = 0, pipeline valid tags = 0, o_data = 0. Anything in flight is discarded.
- Stage 1: the nine products are registered on the edge where the image-mode column is accepted, using the new column.
- Stage 2: the adder tree result is registered into o_data.
- Latency: a column accepted at edge N gives o_data valid after edge N+2. Sustained throughput is 1 result per cycle.
- o_data changes only on edges where stage 2 carries a valid tag; otherwise it holds its last value.
- Kernel loads take effect for any column accepted on a later edge.
- Kernel load and image column in the same cycle are impossible (single mode bit).

## Configuration
- Macro: CONV_ROUND_EN.
- Defined:
  - Add 2^(CONV_LEN-CONV_LPOS-1) = 64 to the accumulator before slicing (round half up).
  - Clamp to the most positive CONV_LPOS value if the addition overflows.
- Undefined: plain truncation as above.

## Structure
- Shared package conv_pkg holds:
  - width constants BIT_LEN, CONV_LEN, CONV_LPOS, M_LEN;
  - the derived shift amount;
  - the rounding constant.
- One natural sub-module: conv_mac. It contains the 9 multipliers, the stage-1 registers and the adder tree. The top holds the K/W shift registers, the valid tags and the output slice.

## Test plan
- Reset mid-stream: launch image columns, assert i_reset asynchronously → o_data = 0 immediately. After release, stage 2 does not update until new valid columns arrive.
- Identity-half kernel:
  - Load K columns (0,0,0), (0,64,0), (0,0,0).
  - Stream image columns (0,0,0), (0,100,0), (0,0,0).
  - Expect 50 two cycles after the third column.
- Full positive: K all 127, image all 127 → acc 145161 → o_data 1134. Streaming three more identical columns back-to-back → 1134 every cycle.
- Signs: K all −128, image all −128 → o_data 1152. K all 127, image all −128 → o_data −1143.
- Hold: with i_valid low for 5 cycles, o_data is unchanged. A kernel-mode load does not alter o_data or W.
- Rounding: K center = 1, others 0, pixel center = 64 → o_data 0 without CONV_ROUND_EN, 1 with it.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, derived shift and rounding constant for the 3x3 convolver.
// CONV_ROUND_EN selects round-half-up with clamp instead of truncation.
package conv_pkg;
   localparam int BIT_LEN   = 8;
   localparam int CONV_LEN  = 2 * BIT_LEN + 4;
   localparam int CONV_LPOS = 13;
   localparam int M_LEN     = 3;
   localparam int SHIFT     = CONV_LEN - CONV_LPOS;

   localparam logic [CONV_LEN:0] RND_K = (CONV_LEN + 1)'(1) << (SHIFT - 1);

   typedef logic signed [BIT_LEN-1:0]   smp_t;
   typedef smp_t [M_LEN-1:0]            col_t;
   typedef col_t [M_LEN-1:0]            mat_t;
   typedef logic signed [CONV_LPOS-1:0] out_t;
endpackage

// File: rtl/conv_if.sv
// Column stream and result bus of the 3x3 convolver.
interface conv_if;
   import conv_pkg::*;

   logic i_selecK_I;
   logic i_valid;
   smp_t i_dato0;
   smp_t i_dato1;
   smp_t i_dato2;
   out_t o_data;

   modport master (
      output i_selecK_I, i_valid,
      output i_dato0, i_dato1, i_dato2,
      input  o_data
   );

   modport slave (
      input  i_selecK_I, i_valid,
      input  i_dato0, i_dato1, i_dato2,
      output o_data
   );
endinterface

// File: rtl/conv_mac.sv
// Nine signed multipliers, stage-1 product registers and the adder tree.
module conv_mac
   import conv_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       en_i,
   input  mat_t                       k_i,
   input  mat_t                       w_i,
   output logic signed [CONV_LEN-1:0] acc_o
);

   localparam int NP = M_LEN * M_LEN;

   logic signed [2*BIT_LEN-1:0] prod_d [NP];
   logic signed [2*BIT_LEN-1:0] prod_q [NP];

   always_comb begin
      for (int c = 0; c < M_LEN; c++) begin
         for (int r = 0; r < M_LEN; r++) begin
            prod_d[c*M_LEN+r] = $signed(k_i[c][r]) * $signed(w_i[c][r]);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NP; i++) prod_q[i] <= '0;
      end else if (en_i) begin
         prod_q <= prod_d;
      end
   end

   // Products are sign-extended before summing; nine 16-bit terms fit in 20.
   always_comb begin
      acc_o = '0;
      for (int i = 0; i < NP; i++) begin
         acc_o = acc_o + CONV_LEN'(prod_q[i]);
      end
   end

endmodule

// File: rtl/conv.sv
// 3x3 signed streaming convolver: kernel/window shift registers and output.
// Build with CONV_ROUND_EN for round-half-up with positive clamp.
module conv
   import conv_pkg::*;
(
   input  logic   CLK100MHZ,
   input  logic   i_reset,
   conv_if.slave  bus
);

   mat_t k_q, k_d;
   mat_t w_q, w_d;
   col_t col;
   logic v1_q, v1_d;
   logic v2_q;
   out_t o_q, o_d;

   logic signed [CONV_LEN-1:0] acc;
   logic signed [CONV_LEN-1:0] acc_q;

   assign col = {bus.i_dato2, bus.i_dato1, bus.i_dato0};

   // Newest column lands in index 0 for both kernel and window.
   always_comb begin
      k_d  = k_q;
      w_d  = w_q;
      v1_d = 1'b0;
      if (bus.i_valid) begin
         if (bus.i_selecK_I) begin
            w_d  = {w_q[1], w_q[0], col};
            v1_d = 1'b1;
         end else begin
            k_d  = {k_q[1], k_q[0], col};
         end
      end
   end

   conv_mac u_mac (
      .clk_i (CLK100MHZ),
      .rst_i (i_reset),
      .en_i  (v1_d),
      .k_i   (k_q),
      .w_i   (w_d),
      .acc_o (acc)
   );

`ifdef CONV_ROUND_EN
   logic signed [CONV_LEN:0] rnd;
   logic signed [CONV_LEN:0] rnd_sh;

   always_comb begin
      rnd    = $signed({acc_q[CONV_LEN-1], acc_q} + RND_K);
      rnd_sh = rnd >>> SHIFT;
      o_d    = CONV_LPOS'(rnd_sh);
      if (rnd[CONV_LEN] != rnd[CONV_LEN-1]) begin
         o_d = {1'b0, {(CONV_LPOS-1){1'b1}}};
      end
   end
`else
   logic signed [CONV_LEN-1:0] acc_sh;

   always_comb begin
      acc_sh = acc_q >>> SHIFT;
      o_d    = CONV_LPOS'(acc_sh);
   end
`endif

   always_ff @(posedge CLK100MHZ or posedge i_reset) begin
      if (i_reset) begin
         k_q   <= '0;
         w_q   <= '0;
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         acc_q <= '0;
         o_q   <= '0;
      end else begin
         k_q  <= k_d;
         w_q  <= w_d;
         v1_q <= v1_d;
         v2_q <= v1_q;
         if (v1_q) acc_q <= acc;
         if (v2_q) o_q   <= o_d;
      end
   end

   assign bus.o_data = o_q;

endmodule

// File: tb/tb_conv.sv
// Directed scoreboard bench for conv.
module tb_conv;
   import conv_pkg::*;

   logic CLK100MHZ = 1'b0;
   logic i_reset   = 1'b1;

   conv_if bus ();

   conv dut (
      .CLK100MHZ (CLK100MHZ),
      .i_reset   (i_reset),
      .bus       (bus)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   int   total = 0;
   int   bad   = 0;
   out_t sb[$];
   out_t last  = '0;
   bit   p1    = 1'b0;
   bit   p2    = 1'b0;
   int   kq[3][3];
   int   wq[3][3];

   function automatic int model();
      int acc;
      int r;
      acc = 0;
      for (int c = 0; c < 3; c++)
         for (int j = 0; j < 3; j++)
            acc += kq[c][j] * wq[c][j];
`ifdef CONV_ROUND_EN
      r = (acc + 64) >>> 7;
      if (r > 4095) r = 4095;
`else
      r = acc >>> 7;
`endif
      return r;
   endfunction

   task automatic chk(string tag, out_t got, out_t exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clr_model();
      for (int c = 0; c < 3; c++)
         for (int j = 0; j < 3; j++) begin
            kq[c][j] = 0;
            wq[c][j] = 0;
         end
   endtask

   task automatic cyc(bit v, bit s, int a, int b, int c);
      bit launch;
      bus.i_valid    = v;
      bus.i_selecK_I = s;
      bus.i_dato0    = smp_t'(a);
      bus.i_dato1    = smp_t'(b);
      bus.i_dato2    = smp_t'(c);
      @(posedge CLK100MHZ);
      launch = 1'b0;
      if (v && s) begin
         wq[2] = wq[1];
         wq[1] = wq[0];
         wq[0] = '{a, b, c};
         launch = 1'b1;
         sb.push_back(out_t'(model()));
      end else if (v) begin
         kq[2] = kq[1];
         kq[1] = kq[0];
         kq[0] = '{a, b, c};
      end
      #1;
      if (p2) begin
         total++;
         assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL sb_empty got=%0d exp=1", sb.size());
         end
         if (sb.size() > 0) last = sb.pop_front();
      end
      p2 = p1;
      p1 = launch;
      chk("o_data", bus.o_data, last);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic kcol(int a, int b, int c);
      cyc(1'b1, 1'b0, a, b, c);
   endtask

   task automatic icol(int a, int b, int c);
      cyc(1'b1, 1'b1, a, b, c);
   endtask

   initial begin
      clr_model();
      bus.i_valid    = 1'b0;
      bus.i_selecK_I = 1'b0;
      bus.i_dato0    = '0;
      bus.i_dato1    = '0;
      bus.i_dato2    = '0;
      repeat (2) @(posedge CLK100MHZ);
      #1;
      chk("reset", bus.o_data, out_t'(0));
      @(negedge CLK100MHZ);
      i_reset = 1'b0;

      kcol(0, 0, 0);
      kcol(0, 64, 0);
      kcol(0, 0, 0);
      icol(0, 0, 0);
      icol(0, 100, 0);
      icol(0, 0, 0);
      idle(2);
      chk("ident", bus.o_data, out_t'(50));

      for (int i = 0; i < 3; i++) kcol(127, 127, 127);
      for (int i = 0; i < 6; i++) icol(127, 127, 127);
      idle(2);
      chk("pos", bus.o_data, out_t'(1134));

      icol(127, 127, 127);
      icol(5, 6, 7);
      #2 i_reset = 1'b1;
      #1 chk("async_rst", bus.o_data, out_t'(0));
      sb.delete();
      p1 = 1'b0;
      p2 = 1'b0;
      last = '0;
      clr_model();
      @(posedge CLK100MHZ);
      #1 chk("rst_hold", bus.o_data, out_t'(0));
      @(negedge CLK100MHZ);
      i_reset = 1'b0;
      idle(3);

      for (int i = 0; i < 3; i++) kcol(-128, -128, -128);
      for (int i = 0; i < 3; i++) icol(-128, -128, -128);
      idle(2);
      chk("negneg", bus.o_data, out_t'(1152));

      for (int i = 0; i < 3; i++) kcol(127, 127, 127);
      for (int i = 0; i < 3; i++) icol(-128, -128, -128);
      idle(2);
      chk("posneg", bus.o_data, out_t'(-1143));

      idle(5);
      chk("hold", bus.o_data, out_t'(-1143));

      kcol(0, 0, 0);
      kcol(0, 1, 0);
      kcol(0, 0, 0);
      chk("kload_hold", bus.o_data, out_t'(-1143));
      icol(0, 0, 0);
      icol(0, 64, 0);
      icol(0, 0, 0);
      idle(2);
`ifdef CONV_ROUND_EN
      chk("round", bus.o_data, out_t'(1));
`else
      chk("round", bus.o_data, out_t'(0));
`endif
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
